// File: rtl/leaf_loader_pkg.sv
// Shared types and constants for the leaf-FIFO run loader.
package leaf_loader_pkg;

  localparam int REC_W = 32;
  localparam logic [REC_W-1:0] TERMINATOR = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    TERM
  } state_e;

endpackage

// File: rtl/beat_serializer.sv
// W-lane beat buffer: loads a whole beat, then hands out lanes in order,
// lane 0 first, one per pop.
module beat_serializer
  import leaf_loader_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [REC_W*W-1:0] data_i,
  input  logic               pop_i,
  input  logic               clear_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [REC_W-1:0]   rec_o
);

  logic [REC_W*W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   laneIdx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // Clear wins over load so a finished job never keeps stale lanes.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      buf_d = data_i;
      cnt_d = CNT_W'(W);
    end else if (pop_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // The next lane to hand out is W-cnt; an empty buffer selects nothing.
  always_comb begin
    laneIdx = CNT_W'(W) - cnt_q;
    rec_o   = '0;
    for (int i = 0; i < W; i++) begin
      if (laneIdx == CNT_W'(i)) begin
        rec_o = buf_q[i*REC_W +: REC_W];
      end
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/leaf_run_loader.sv
// Serializes wide record beats into N_LEAF leaf FIFOs, one zero-terminated run per leaf.
// Optional stall counter output enabled by defining LEAF_LOADER_STALL_CNT_EN.
module leaf_run_loader
  import leaf_loader_pkg::*;
#(
  parameter int N_LEAF = 128,
  parameter int W      = 8,
  parameter int LEN_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [LEN_W-1:0]   i_run_len,
  input  logic [REC_W*W-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N_LEAF-1:0]  i_leaf_full,
  output logic [REC_W-1:0]   o_leaf_data,
  output logic [N_LEAF-1:0]  o_leaf_write,
  output logic               o_busy,
  output logic               o_done
`ifdef LEAF_LOADER_STALL_CNT_EN
  ,
  output logic [31:0]        o_stall_cycles
`endif
);

  localparam int LEAF_W = $clog2(N_LEAF);
  localparam int CNT_W  = $clog2(W) + 1;

  state_e            state_q, state_d;
  logic [LEAF_W-1:0] leaf_q, leaf_d;
  logic [LEN_W-1:0]  rec_q, rec_d;
  logic [LEN_W-1:0]  runLen_q, runLen_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  serCnt;
  logic [REC_W-1:0]  serRec;
  logic              serLoad, serPop, serClear;
  logic              wrEn;
  logic [REC_W-1:0]  wrData;
  logic              stall;
  logic              leafFull, lastLeaf, bufEmpty, startOk;

  beat_serializer #(.W(W), .CNT_W(CNT_W)) u_ser (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (serLoad),
    .data_i  (i_data),
    .pop_i   (serPop),
    .clear_i (serClear),
    .cnt_o   (serCnt),
    .rec_o   (serRec)
  );

  assign leafFull = i_leaf_full[leaf_q];
  assign lastLeaf = (leaf_q == LEAF_W'(N_LEAF - 1));
  assign bufEmpty = (serCnt == '0);
  // A start landing on the done pulse is dropped along with starts while busy.
  assign startOk  = (state_q == IDLE) && i_start && !done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      leaf_q   <= '0;
      rec_q    <= '0;
      runLen_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      leaf_q   <= leaf_d;
      rec_q    <= rec_d;
      runLen_q <= runLen_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    leaf_d   = leaf_q;
    rec_d    = rec_q;
    runLen_d = runLen_q;
    done_d   = 1'b0;
    serLoad  = 1'b0;
    serPop   = 1'b0;
    serClear = 1'b0;
    wrEn     = 1'b0;
    wrData   = TERMINATOR;
    o_ready  = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOk) begin
          state_d  = LOAD;
          runLen_d = (i_run_len == '0) ? LEN_W'(1) : i_run_len;
          leaf_d   = '0;
          rec_d    = '0;
          serClear = 1'b1;
        end
      end
      LOAD: begin
        if (bufEmpty) begin
          o_ready = 1'b1;
          serLoad = i_valid;
        end else if (!leafFull) begin
          wrEn   = 1'b1;
          wrData = serRec;
          serPop = 1'b1;
          rec_d  = rec_q + LEN_W'(1);
          if (rec_q == runLen_q - LEN_W'(1)) begin
            state_d = TERM;
          end
        end else begin
          stall = 1'b1;
        end
      end
      TERM: begin
        // Prefetch the next leaf's beat during the terminator; the last leaf needs none.
        if (bufEmpty && !lastLeaf) begin
          o_ready = 1'b1;
          serLoad = i_valid;
        end
        if (!leafFull) begin
          wrEn  = 1'b1;
          rec_d = '0;
          if (lastLeaf) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            serClear = 1'b1;
          end else begin
            leaf_d  = leaf_q + LEAF_W'(1);
            state_d = LOAD;
          end
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_leaf_write = wrEn ? (N_LEAF'(1) << leaf_q) : '0;
  assign o_leaf_data  = wrEn ? wrData : '0;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;

`ifdef LEAF_LOADER_STALL_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (startOk) begin
      stallCnt_d = '0;
    end else if (stall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  assign o_stall_cycles = stallCnt_q;
`endif

endmodule

// File: tb/tb_leaf_run_loader.sv
// Directed self-checking bench for leaf_run_loader with N_LEAF=4, W=4.
module tb_leaf_run_loader;

  localparam int N  = 4;
  localparam int WB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [15:0]   i_run_len = '0;
  logic [127:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [N-1:0]  i_leaf_full = '0;
  logic [31:0]   o_leaf_data;
  logic [N-1:0]  o_leaf_write;
  logic          o_busy;
  logic          o_done;
`ifdef LEAF_LOADER_STALL_CNT_EN
  logic [31:0]   o_stall_cycles;
`endif

  leaf_run_loader #(.N_LEAF(N), .W(WB), .LEN_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_run_len    (i_run_len),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_leaf_full  (i_leaf_full),
    .o_leaf_data  (o_leaf_data),
    .o_leaf_write (o_leaf_write),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef LEAF_LOADER_STALL_CNT_EN
    ,
    .o_stall_cycles (o_stall_cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  int          wrLeaf[$];
  logic [31:0] wrData[$];
  int          expLeaf[$];
  logic [31:0] expData[$];
  int beats, doneCount, firstWr, doneCyc, stallWrites, gapViol, hotViol;
  int postDoneWrites, postBusy, expBeats, timedOut;
  int leafWr[N];

  function automatic logic [127:0] makeBeat(input int b);
    logic [127:0] v;
    for (int j = 0; j < WB; j++) v[j*32 +: 32] = 32'(b * WB + j + 1);
    return v;
  endfunction

  // Records are numbered 1.. in arrival order; each leaf gets its run then a zero.
  task automatic buildExp(input int runLen);
    int eff;
    int v;
    eff = (runLen == 0) ? 1 : runLen;
    v = 1;
    expLeaf.delete();
    expData.delete();
    for (int l = 0; l < N; l++) begin
      for (int r = 0; r < eff; r++) begin
        expLeaf.push_back(l);
        expData.push_back(32'(v));
        v++;
      end
      expLeaf.push_back(l);
      expData.push_back(32'h0);
    end
    expBeats = (N * eff + WB - 1) / WB;
  endtask

  // Runs one job cycle by cycle: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
  task automatic runJob(input int runLen, input int gapAfter, input int gapLen,
                        input int stallAtRec, input int stallLen,
                        input int busyStartCyc, input bit startAtDone);
    int c, postCyc, gapLeft, stallLeft;
    bit gapStarted, stallStarted, gapCyc, stallCyc;
    wrLeaf.delete();
    wrData.delete();
    beats = 0; doneCount = 0; firstWr = -1; doneCyc = -1;
    stallWrites = 0; gapViol = 0; hotViol = 0; postDoneWrites = 0; postBusy = 0;
    timedOut = 1;
    for (int l = 0; l < N; l++) leafWr[l] = 0;
    gapStarted = 0; stallStarted = 0; gapLeft = 0; stallLeft = 0; postCyc = 0;
    i_run_len = 16'(runLen);
    for (c = 0; c < 2000; c++) begin
      @(posedge i_clk);
      #1;
      i_start = (c == 0) || (c == busyStartCyc) || (startAtDone && o_done);
      if (!gapStarted && gapAfter >= 0 && beats == gapAfter && o_ready) begin
        gapStarted = 1;
        gapLeft = gapLen;
      end
      gapCyc = (gapLeft > 0);
      if (gapCyc) gapLeft--;
      i_valid = !gapCyc;
      i_data = makeBeat(beats);
      if (!stallStarted && stallAtRec >= 0 && leafWr[1] == stallAtRec) begin
        stallStarted = 1;
        stallLeft = stallLen;
      end
      stallCyc = (stallLeft > 0);
      if (stallCyc) stallLeft--;
      i_leaf_full = stallCyc ? 4'b0010 : 4'b0000;
      @(negedge i_clk);
      if (i_valid && o_ready) beats++;
      if (gapCyc && (o_ready !== 1'b1 || o_leaf_write != '0)) gapViol++;
      if (stallCyc && o_leaf_write != '0) stallWrites++;
      if (o_leaf_write != '0) begin
        if ($countones(o_leaf_write) != 1) hotViol++;
        for (int l = 0; l < N; l++) begin
          if (o_leaf_write[l]) begin
            wrLeaf.push_back(l);
            wrData.push_back(o_leaf_data);
            leafWr[l]++;
          end
        end
        if (firstWr < 0) firstWr = c;
        if (doneCount > 0) postDoneWrites++;
      end else if (o_leaf_data != '0) begin
        hotViol++;
      end
      if (doneCount > 0 && o_busy) postBusy++;
      if (o_done) begin
        doneCount++;
        doneCyc = c;
      end
      if (doneCount > 0) postCyc++;
      if (postCyc == 6) begin
        timedOut = 0;
        break;
      end
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    i_leaf_full = '0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    #12;
    checks++;
    if (o_leaf_write !== '0 || o_leaf_data !== '0 || o_ready !== 1'b0 ||
        o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got wr=%b data=%h rdy=%b busy=%b done=%b, want all 0",
               o_leaf_write, o_leaf_data, o_ready, o_busy, o_done);
    end
`ifdef LEAF_LOADER_STALL_CNT_EN
    checks++;
    if (o_stall_cycles !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_stall_cnt: got %0d want 0", o_stall_cycles);
    end
`endif
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    buildExp(4);
    runJob(4, -1, 0, -1, 0, -1, 0);
    checks++;
    if (timedOut != 0) begin errors++; $display("[TB] FAIL basic_timeout: got no done, want done"); end
    checks++;
    if (wrLeaf.size() != expLeaf.size()) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d writes want %0d", wrLeaf.size(), expLeaf.size());
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL basic_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
    checks++;
    if (beats != 4) begin errors++; $display("[TB] FAIL basic_beats: got %0d want 4", beats); end
    checks++;
    if (doneCyc - firstWr != 20) begin
      errors++;
      $display("[TB] FAIL basic_done_latency: got %0d want 20", doneCyc - firstWr);
    end
    checks++;
    if (hotViol != 0 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL basic_strobe: got hotViol %0d done %0d want 0 and 1", hotViol, doneCount);
    end
  endtask

  task automatic test_cross_leaf;
    buildExp(3);
    runJob(3, -1, 0, -1, 0, -1, 0);
    checks++;
    if (wrLeaf.size() != expLeaf.size() || timedOut != 0) begin
      errors++;
      $display("[TB] FAIL cross_count: got %0d writes timeout %0d want %0d and 0",
               wrLeaf.size(), timedOut, expLeaf.size());
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL cross_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
    checks++;
    if (beats != 3) begin errors++; $display("[TB] FAIL cross_beats: got %0d want 3", beats); end
  endtask

  task automatic test_stall;
    buildExp(4);
    runJob(4, -1, 0, 2, 10, -1, 0);
    checks++;
    if (stallWrites != 0) begin
      errors++;
      $display("[TB] FAIL stall_writes: got %0d want 0", stallWrites);
    end
    checks++;
    if (wrLeaf.size() != expLeaf.size() || timedOut != 0) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d writes timeout %0d want %0d and 0",
               wrLeaf.size(), timedOut, expLeaf.size());
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL stall_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
    checks++;
    if (doneCyc - firstWr != 30) begin
      errors++;
      $display("[TB] FAIL stall_done_latency: got %0d want 30", doneCyc - firstWr);
    end
`ifdef LEAF_LOADER_STALL_CNT_EN
    checks++;
    if (o_stall_cycles !== 32'd10) begin
      errors++;
      $display("[TB] FAIL stall_cycles: got %0d want 10", o_stall_cycles);
    end
`endif
  endtask

  task automatic test_valid_gap;
    buildExp(3);
    runJob(3, 1, 5, -1, 0, -1, 0);
    checks++;
    if (gapViol != 0) begin
      errors++;
      $display("[TB] FAIL gap_ready_idle: got %0d bad gap cycles want 0", gapViol);
    end
    checks++;
    if (wrLeaf.size() != expLeaf.size() || beats != 3) begin
      errors++;
      $display("[TB] FAIL gap_count: got %0d writes %0d beats want %0d and 3",
               wrLeaf.size(), beats, expLeaf.size());
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL gap_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    buildExp(4);
    runJob(4, -1, 0, -1, 0, 6, 1);
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("[TB] FAIL start_done_once: got %0d want 1", doneCount);
    end
    checks++;
    if (postBusy != 0 || postDoneWrites != 0) begin
      errors++;
      $display("[TB] FAIL start_at_done: got busy %0d writes %0d after done want 0 and 0",
               postBusy, postDoneWrites);
    end
    checks++;
    if (wrLeaf.size() != expLeaf.size() || beats != 4) begin
      errors++;
      $display("[TB] FAIL start_count: got %0d writes %0d beats want %0d and 4",
               wrLeaf.size(), beats, expLeaf.size());
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL start_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
  endtask

  task automatic test_run_len_zero;
    buildExp(0);
    runJob(0, -1, 0, -1, 0, -1, 0);
    checks++;
    if (wrLeaf.size() != 8 || beats != 1) begin
      errors++;
      $display("[TB] FAIL zero_len_count: got %0d writes %0d beats want 8 and 1",
               wrLeaf.size(), beats);
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL zero_len_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    seen = 0;
    i_run_len = 16'd4;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge i_clk);
      #1;
      i_start = (c == 0);
      i_valid = 1'b1;
      i_data = makeBeat(0);
      @(negedge i_clk);
      if (o_leaf_write != '0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL rst_mid_setup: got no write within 20 cycles, want a write");
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_leaf_write !== '0 || o_busy !== 1'b0 || o_leaf_data !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got wr=%b busy=%b data=%h want 0 0 0",
               o_leaf_write, o_busy, o_leaf_data);
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    buildExp(2);
    runJob(2, -1, 0, -1, 0, -1, 0);
    checks++;
    if (wrLeaf.size() != expLeaf.size() || beats != 2) begin
      errors++;
      $display("[TB] FAIL rst_mid_restart_count: got %0d writes %0d beats want %0d and 2",
               wrLeaf.size(), beats, expLeaf.size());
    end
    for (int i = 0; i < expLeaf.size(); i++) begin
      checks++;
      if (i >= wrLeaf.size() || wrLeaf[i] != expLeaf[i] || wrData[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL rst_mid_seq[%0d]: got leaf %0d data %0h want leaf %0d data %0h", i,
                 (i < wrLeaf.size()) ? wrLeaf[i] : -1, (i < wrData.size()) ? wrData[i] : 32'hx,
                 expLeaf[i], expData[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cross_leaf();
    test_stall();
    test_valid_gap();
    test_start_ignored();
    test_run_len_zero();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leaf_run_loader.md
Name: leaf_run_loader

Overview:
- Writer side of the merger tree's leaf-FIFO interface.
- Accepts a wide stream of 32-bit records, W records per beat, from the memory read path.
- Serializes the stream one record per cycle into N_LEAF leaf FIFOs. Run k (i_run_len records) goes to leaf k in order, and each run is closed with a zero terminator record.
- Sits between the DRAM read unit and the leaf FIFOs that feed the merger tree's first MERGER_1 level.

Parameters:
N_LEAF, 128, number of leaf FIFOs (2*L of the tree); power of two, >=2
W, 8, records per input beat; power of two, >=1
LEN_W, 16, width of the run-length field

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle start pulse; ignored unless idle
i_run_len  input  LEN_W  records per run, sampled when i_start is accepted; value 0 treated as 1
i_data  input  32*W  input beat; lane 0 = bits [31:0] is the first record
i_valid  input  1  beat valid
o_ready  output  1  beat accepted when i_valid & o_ready
i_leaf_full  input  N_LEAF  full flags of the leaf FIFOs
o_leaf_data  output  32  record to the leaf FIFOs (shared bus)
o_leaf_write  output  N_LEAF  one-hot enqueue strobe
o_busy  output  1  high from the cycle after start is accepted until the done pulse
o_done  output  1  one-cycle pulse after the last terminator is written

Behaviour:
- Reset values: all outputs 0; state IDLE; leaf index 0; record and lane counters 0; beat buffer empty.
- State machine states:
  - IDLE: i_start -> LOAD. Latch i_run_len, set leaf=0, rec=0, lane count=0.
  - LOAD:
    - Beat buffer empty (cnt==0): o_ready=1. An accepted beat loads buffer, cnt=W.
    - cnt>0 and ~i_leaf_full[leaf]: o_leaf_write[leaf]=1, o_leaf_data=lane[W-cnt], cnt--, rec++.
    - After writing the record where rec+1==run_len, next state is TERM.
  - TERM:
    - If ~i_leaf_full[leaf], write 32'h0 to leaf and clear rec.
    - If leaf==N_LEAF-1: go to IDLE, pulse o_done, discard remaining buffered lanes (cnt=0).
    - Otherwise: leaf++, back to LOAD. Remaining buffered lanes continue into the new leaf.
- Latency: beat accepted at cycle t, first record written at t+1 if its leaf is not full.
- Throughput: at most one write per cycle. Each leaf receives run_len+1 writes.
- Beats consumed per job: exactly ceil(N_LEAF*run_len/W). Extra lanes in the final beat are dropped.
- Backpressure: a full leaf stalls everything. No write is issued to a full leaf; buffer and counters hold.
- o_ready is never high while cnt>0 (no overlap of accept and drain).
- o_leaf_data and o_leaf_write are combinational from registered state and i_leaf_full only. No i_valid→o_leaf_* path.
- o_leaf_data is 0 whenever o_leaf_write==0.
- i_start while busy: ignored. i_start coincident with o_done: ignored.
- Records equal to 0 in i_data are forwarded unchanged. Callers must not send them, since downstream mergers read 0 as a terminator.
- Reset mid-job: writes deassert immediately (asynchronous), partial runs are abandoned, and the next job restarts at leaf 0.

Optional Feature:
- Macro LEAF_LOADER_STALL_CNT_EN, defined:
  - Adds output o_stall_cycles [31:0].
  - Counts cycles in LOAD/TERM where a record is pending but i_leaf_full[leaf]=1.
  - Cleared on reset and on an accepted i_start; saturates at all-ones.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package leaf_loader_pkg:
  - TERMINATOR constant 32'h0.
  - State enum (IDLE, LOAD, TERM).
  - REC_W=32.
- One sub-module, beat_serializer: W-lane buffer with load/pop, cnt, and lane-select mux. The top keeps the FSM, leaf index, run counter and one-hot decode.

Test Plan:
- N_LEAF=4, W=4, run_len=4, beats 1..4 of values 1..16, no full → leaf0 gets 1,2,3,4,0; leaf3 gets 13,14,15,16,0. Expect o_done 20 cycles after the first write; 4 beats consumed.
- run_len=3, W=4 → leaf0 1,2,3,0; leaf1 4,5,6,0 (lane 3 of beat 1 crosses to the next leaf); 3 beats consumed.
- Hold i_leaf_full[1]=1 for 10 cycles mid-run → no writes during the stall, no data lost, order preserved. With the _EN macro, o_stall_cycles=10.
- i_valid low for 5 cycles between beats → o_ready stays 1, no writes, then resume with the correct next value.
- Assert i_start while busy → ignored; o_done pulses exactly once per job.
- Assert i_rst_n=0 mid-run → o_leaf_write=0 in the same cycle. A new job starts at leaf 0 with clean runs.
